menu_button_bank: RTL and testbench

// Parametrised bank of N vertically stacked clickable text buttons for the VGA menu screens.

---
 rtl/menu_button_bank_if.sv | 30 +++
 rtl/menu_button_bank.sv | 216 +++++++++++++++++++++
 tb/tb_menu_button_bank.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/menu_button_bank_if.sv
// Video chain bundle for menu_button_bank: the hcount/vcount/sync/blank/rgb
// signals entering the block (*_in) and the same set leaving it (*_out).
//   slave  : the bank itself (consumes *_in, produces *_out)
//   master : upstream/downstream side (drives *_in, observes *_out)
interface menu_button_bank_if;
  logic [11:0] hcount_in;
  logic [11:0] vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] hcount_out;
  logic [11:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
  );

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
  );
endinterface

// File: rtl/menu_button_bank.sv
// menu_button_bank: N vertically stacked clickable text buttons drawn inline
// in the VGA chain (2 clocks of latency), plus a mouse click FSM.
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   vid (slave)       video timing/colour in and out (see menu_button_bank_if)
//   enable            per-button display and click enable
//   xpos, ypos        mouse position
//   mouse_left        left button level, 1 = pressed
//   text_addr         {button index, char column} to the combinational text ROM
//   char_line         font row within the character cell
//   char_pixels       font row, valid one clk after text_addr/char_line, MSB left
//   hover             one-hot (or zero): mouse over an enabled button
//   clicked           one-clk pulse per completed click
module menu_button_bank #(
  parameter int unsigned N_BUTTONS  = 3,
  parameter int unsigned BOX_X_POS  = 432,
  parameter int unsigned BOX_Y_POS  = 400,
  parameter int unsigned BOX_X_SIZE = 128,
  parameter int unsigned BOX_Y_SIZE = 80,
  parameter int unsigned BOX_Y_GAP  = 40,
  parameter int unsigned TEXT_X_OFF = 32,
  parameter int unsigned TEXT_Y_OFF = 32,
  parameter int unsigned TEXT_CHARS = 8,
  parameter logic [11:0] COL_IDLE   = 12'h444,
  parameter logic [11:0] COL_HOVER  = 12'h888,
  parameter logic [11:0] COL_PRESS  = 12'hCC0,
  parameter logic [11:0] COL_TEXT   = 12'hFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  menu_button_bank_if.slave    vid,
  input  logic [N_BUTTONS-1:0] enable,
  input  logic [11:0]          xpos,
  input  logic [11:0]          ypos,
  input  logic                 mouse_left,
  output logic [5:0]           text_addr,
  output logic [3:0]           char_line,
  input  logic [7:0]           char_pixels,
  output logic [N_BUTTONS-1:0] hover,
  output logic [N_BUTTONS-1:0] clicked
);

  localparam logic [11:0] X_LO  = 12'(BOX_X_POS);
  localparam logic [11:0] X_HI  = 12'(BOX_X_POS + BOX_X_SIZE);
  localparam logic [11:0] TX_LO = 12'(BOX_X_POS + TEXT_X_OFF);
  localparam logic [11:0] TX_HI = 12'(BOX_X_POS + TEXT_X_OFF + TEXT_CHARS * 8);

  typedef enum logic [1:0] {IDLE, ARMED, BLOCKED} state_t;

  function automatic logic [11:0] btn_top(input int unsigned k);
    return 12'(BOX_Y_POS + k * (BOX_Y_SIZE + BOX_Y_GAP));
  endfunction

  function automatic logic in_btn(input logic [11:0] x, input logic [11:0] y,
                                  input int unsigned k);
    logic [11:0] t;
    t = btn_top(k);
    return (x >= X_LO) && (x < X_HI) && (y >= t) && (y < t + 12'(BOX_Y_SIZE));
  endfunction

  // ---------------- stage 1 decode (combinational) ----------------
  logic        hit_c, txt_c;
  logic [1:0]  idx_c;
  logic [11:0] ty_c, dx_c, dy_c;

  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    ty_c  = '0;
    for (int unsigned k = 0; k < N_BUTTONS; k++) begin
      if (in_btn(vid.hcount_in, vid.vcount_in, k)) begin
        hit_c = 1'b1;
        idx_c = 2'(k);
        ty_c  = btn_top(k) + 12'(TEXT_Y_OFF);
      end
    end
    dx_c  = vid.hcount_in - TX_LO;
    dy_c  = vid.vcount_in - ty_c;
    txt_c = hit_c && (vid.hcount_in >= TX_LO) && (vid.hcount_in < TX_HI) &&
            (vid.vcount_in >= ty_c) && (vid.vcount_in < ty_c + 12'd16);
  end

  // Address goes out combinationally so the font row returns in time for the
  // stage-2 register, keeping the whole chain at two clocks.
  assign text_addr = (txt_c && !rst) ? {idx_c, 4'(dx_c >> 3)} : '0;
  assign char_line = (txt_c && !rst) ? 4'(dy_c) : '0;

  // ---------------- click FSM ----------------
  state_t              state, state_nxt;
  logic [1:0]          latched, latched_nxt;
  logic [N_BUTTONS-1:0] click_nxt;
  logic                mouse_d;
  logic                rise, fall, any_hover;
  logic [1:0]          hover_idx;

  always_comb begin
    hover_idx = '0;
    for (int unsigned k = 0; k < N_BUTTONS; k++)
      if (hover[k]) hover_idx = 2'(k);
  end

  assign any_hover = |hover;
  assign rise      = mouse_left && !mouse_d;
  assign fall      = !mouse_left && mouse_d;

  always_comb begin
    state_nxt   = state;
    latched_nxt = latched;
    click_nxt   = '0;
    case (state)
      IDLE: begin
        if (rise) begin
          if (any_hover) begin
            state_nxt   = ARMED;
            latched_nxt = hover_idx;
          end else begin
            state_nxt = BLOCKED;
          end
        end
      end
      ARMED: begin
        if (!enable[latched]) begin
          state_nxt = mouse_left ? BLOCKED : IDLE;
        end else if (fall) begin
          state_nxt = IDLE;
          if (hover[latched]) click_nxt[latched] = 1'b1;
        end
      end
      BLOCKED: begin
        if (!mouse_left) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mouse_d follows mouse_left even during reset, so a button held through
  // reset produces no rising edge afterwards and must be re-pressed.
  always_ff @(posedge clk) begin
    mouse_d <= mouse_left;
    if (rst) begin
      state   <= IDLE;
      latched <= '0;
      clicked <= '0;
      hover   <= '0;
    end else begin
      state   <= state_nxt;
      latched <= latched_nxt;
      clicked <= click_nxt;
      for (int unsigned k = 0; k < N_BUTTONS; k++)
        hover[k] <= enable[k] && in_btn(xpos, ypos, k);
    end
  end

  // ---------------- video pipeline ----------------
  logic [11:0] hcount_d1, vcount_d1, rgb_d1;
  logic        hsync_d1, vsync_d1, hblnk_d1, vblnk_d1;
  logic        hit_d1, txt_d1;
  logic [1:0]  idx_d1;
  logic [2:0]  xo_d1;
  logic [11:0] fill_col;

  always_comb begin
    fill_col = COL_IDLE;
    if (hover[idx_d1])
      fill_col = (state == ARMED && latched == idx_d1) ? COL_PRESS : COL_HOVER;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_d1      <= '0;
      vcount_d1      <= '0;
      rgb_d1         <= '0;
      hsync_d1       <= 1'b0;
      vsync_d1       <= 1'b0;
      hblnk_d1       <= 1'b0;
      vblnk_d1       <= 1'b0;
      hit_d1         <= 1'b0;
      txt_d1         <= 1'b0;
      idx_d1         <= '0;
      xo_d1          <= '0;
      vid.hcount_out <= '0;
      vid.vcount_out <= '0;
      vid.hsync_out  <= 1'b0;
      vid.vsync_out  <= 1'b0;
      vid.hblnk_out  <= 1'b0;
      vid.vblnk_out  <= 1'b0;
      vid.rgb_out    <= '0;
    end else begin
      hcount_d1      <= vid.hcount_in;
      vcount_d1      <= vid.vcount_in;
      rgb_d1         <= vid.rgb_in;
      hsync_d1       <= vid.hsync_in;
      vsync_d1       <= vid.vsync_in;
      hblnk_d1       <= vid.hblnk_in;
      vblnk_d1       <= vid.vblnk_in;
      hit_d1         <= hit_c;
      txt_d1         <= txt_c;
      idx_d1         <= idx_c;
      xo_d1          <= dx_c[2:0];
      vid.hcount_out <= hcount_d1;
      vid.vcount_out <= vcount_d1;
      vid.hsync_out  <= hsync_d1;
      vid.vsync_out  <= vsync_d1;
      vid.hblnk_out  <= hblnk_d1;
      vid.vblnk_out  <= vblnk_d1;
      if (hblnk_d1 || vblnk_d1)
        vid.rgb_out <= '0;
      else if (hit_d1 && enable[idx_d1])
        // ~xo_d1 == 7 - xo_d1: MSB of the font row is the leftmost pixel
        vid.rgb_out <= (txt_d1 && char_pixels[~xo_d1]) ? COL_TEXT : fill_col;
      else
        vid.rgb_out <= rgb_d1;
    end
  end

endmodule

// File: tb/tb_menu_button_bank.sv
module tb_menu_button_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  enable;
  logic [11:0] xpos, ypos;
  logic        mouse_left;
  logic [5:0]  text_addr;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels;
  logic [2:0]  hover, clicked;
  logic        font_force = 1'b0;
  logic [7:0]  font_val = 8'h00;
  int          total = 0;
  int          bad = 0;

  menu_button_bank_if vid ();

  menu_button_bank #(.N_BUTTONS(3)) dut (
    .clk(clk), .rst(rst), .vid(vid), .enable(enable), .xpos(xpos), .ypos(ypos),
    .mouse_left(mouse_left), .text_addr(text_addr), .char_line(char_line),
    .char_pixels(char_pixels), .hover(hover), .clicked(clicked)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic [11:0] hc;
    logic [11:0] vc;
    logic hs, vs, hb, vb;
  } vout_t;
  vout_t vq[$];

  // External ROM pair: text ROM (combinational) feeding a registered font ROM.
  function automatic logic [7:0] text_rom(input logic [5:0] a);
    return 8'(int'(a) * 37 + 5);
  endfunction
  function automatic logic [7:0] font_row(input logic [7:0] code, input int line);
    return code ^ 8'(line * 29 + 7);
  endfunction
  always @(posedge clk)
    char_pixels <= font_force ? font_val : font_row(text_rom(text_addr), int'(char_line));

  // ---------- reference model (geometry from the published parameters) ----------
  function automatic int btn_at(input int x, input int y, input logic [2:0] en);
    for (int k = 0; k < 3; k++) begin
      int top = 400 + 120 * k;
      if (x >= 432 && x < 560 && y >= top && y < top + 80 && en[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [2:0] hover_of(input int x, input int y, input logic [2:0] en);
    int k = btn_at(x, y, en);
    return (k < 0) ? 3'b000 : 3'(1 << k);
  endfunction

  function automatic logic [11:0] ref_rgb(input int x, input int y, input bit blank,
      input logic [11:0] bg, input logic [2:0] en, input int hov, input int pk);
    int k, top, col, line, xo;
    logic [7:0] row;
    if (blank) return 12'h000;
    k = btn_at(x, y, en);
    if (k < 0) return bg;
    top = 400 + 120 * k;
    if (x >= 464 && x < 528 && y >= top + 32 && y < top + 48) begin
      col  = (x - 464) / 8;
      line = y - top - 32;
      xo   = (x - 464) % 8;
      row  = font_force ? font_val : font_row(8'((k * 16 + col) * 37 + 5), line);
      if (row[7 - xo]) return 12'hFFF;
    end
    if (hov == k) return (pk == k) ? 12'hCC0 : 12'h888;
    return 12'h444;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic move(input int x, input int y);
    xpos = 12'(x);
    ypos = 12'(y);
    step();
    step();
  endtask

  // Drives one pixel, records its expectation, and returns the result that
  // emerges two clocks later (v=1 once the pipeline has filled).
  task automatic video_cycle(input int x, input int y, input bit hb, input bit vb,
      input logic [11:0] bg, input int pk, output bit v, output vout_t e, output vout_t g);
    vout_t n;
    n.hs = 1'($urandom);
    n.vs = 1'($urandom);
    n.hb = hb;
    n.vb = vb;
    n.hc = 12'(x);
    n.vc = 12'(y);
    n.rgb = ref_rgb(x, y, hb | vb, bg, enable, btn_at(int'(xpos), int'(ypos), enable), pk);
    vid.hcount_in = 12'(x);
    vid.vcount_in = 12'(y);
    vid.hsync_in  = n.hs;
    vid.vsync_in  = n.vs;
    vid.hblnk_in  = hb;
    vid.vblnk_in  = vb;
    vid.rgb_in    = bg;
    vq.push_back(n);
    step();
    g = {vid.rgb_out, vid.hcount_out, vid.vcount_out,
         vid.hsync_out, vid.vsync_out, vid.hblnk_out, vid.vblnk_out};
    v = 1'b0;
    e = '0;
    if (vq.size() == 2) begin
      e = vq.pop_front();
      v = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    enable = 3'b111;
    mouse_left = 1'b0;
    xpos = 12'd500; ypos = 12'd440;
    vid.hcount_in = 12'd470; vid.vcount_in = 12'd435;
    vid.hsync_in = 1'b1; vid.vsync_in = 1'b1;
    vid.hblnk_in = 1'b0; vid.vblnk_in = 1'b0; vid.rgb_in = 12'hABC;
    repeat (3) step();
    total++; if (vid.rgb_out !== 12'h000) begin bad++; $display("FAIL reset_rgb: got %h want 000", vid.rgb_out); end
    total++; if ({vid.hcount_out, vid.vcount_out} !== 24'h0) begin bad++; $display("FAIL reset_count: got %h %h want 0", vid.hcount_out, vid.vcount_out); end
    total++; if ({vid.hsync_out, vid.vsync_out, vid.hblnk_out, vid.vblnk_out} !== 4'b0) begin bad++; $display("FAIL reset_sync: got %b want 0000", {vid.hsync_out, vid.vsync_out, vid.hblnk_out, vid.vblnk_out}); end
    total++; if ({hover, clicked} !== 6'b0) begin bad++; $display("FAIL reset_mouse: got hover %b clicked %b want 0", hover, clicked); end
    total++; if ({text_addr, char_line} !== 10'b0) begin bad++; $display("FAIL reset_text: got %h %h want 0", text_addr, char_line); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_hover();
    int bx[12] = '{431, 432, 559, 560, 500, 500, 500, 500, 500, 500, 500, 500};
    int by[12] = '{440, 440, 479, 440, 399, 480, 519, 520, 599, 640, 719, 720};
    logic [2:0] bh[12] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000,
                           3'b000, 3'b010, 3'b010, 3'b100, 3'b100, 3'b000};
    enable = 3'b111;
    move(500, 440);
    total++; if (hover !== 3'b001) begin bad++; $display("FAIL hover_basic: got %b want 001", hover); end
    for (int i = 0; i < 12; i++) begin
      move(bx[i], by[i]);
      total++; if (hover !== bh[i]) begin bad++; $display("FAIL hover_edge(%0d,%0d): got %b want %b", bx[i], by[i], hover, bh[i]); end
    end
    for (int i = 0; i < 30; i++) begin
      int x = 400 + int'($urandom_range(0, 200));
      int y = 380 + int'($urandom_range(0, 360));
      enable = 3'($urandom);
      move(x, y);
      total++; if (hover !== hover_of(x, y, enable)) begin bad++; $display("FAIL hover_rand(%0d,%0d,en=%b): got %b want %b", x, y, enable, hover, hover_of(x, y, enable)); end
    end
    enable = 3'b111;
  endtask

  task automatic test_video();
    bit v; vout_t e, g;
    enable = 3'b111;
    move(500, 440);
    vq.delete();
    video_cycle(440, 410, 0, 0, 12'h123, -1, v, e, g);
    video_cycle(0, 0, 0, 0, 12'h000, -1, v, e, g);
    total++; if (g.rgb !== 12'h888) begin bad++; $display("FAIL video_hover_fill: got %h want 888", g.rgb); end
    for (int b = 0; b < 3; b++) begin
      logic [2:0] ens[3] = '{3'b111, 3'b101, 3'b010};
      int mys[3] = '{560, 680, 10};
      enable = ens[b];
      move(500, mys[b]);
      vq.delete();
      for (int i = 0; i < 120; i++) begin
        int x, y;
        if ($urandom_range(0, 1) == 1) begin
          int k = int'($urandom_range(0, 2));
          x = 464 + int'($urandom_range(0, 63));
          y = 400 + 120 * k + 32 + int'($urandom_range(0, 15));
        end else begin
          x = 420 + int'($urandom_range(0, 170));
          y = 390 + int'($urandom_range(0, 340));
        end
        video_cycle(x, y, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    12'($urandom), -1, v, e, g);
        if (v) begin
          total++; if (g !== e) begin bad++; $display("FAIL video_stream: got %h want %h", g, e); end
        end
      end
    end
    enable = 3'b111;
  endtask

  task automatic test_click();
    bit v; vout_t e, g;
    enable = 3'b111;
    move(500, 560);
    mouse_left = 1'b1;
    step(); step();
    vq.delete();
    video_cycle(440, 530, 0, 0, 12'h321, 1, v, e, g);
    video_cycle(440, 410, 0, 0, 12'h321, 1, v, e, g);
    total++; if (g.rgb !== 12'hCC0) begin bad++; $display("FAIL press_fill: got %h want CC0", g.rgb); end
    video_cycle(0, 0, 0, 0, 12'h000, 1, v, e, g);
    total++; if (g.rgb !== 12'h444) begin bad++; $display("FAIL press_other_idle: got %h want 444", g.rgb); end
    total++; if (clicked !== 3'b000) begin bad++; $display("FAIL click_early: got %b want 000", clicked); end
    mouse_left = 1'b0;
    step();
    total++; if (clicked !== 3'b010) begin bad++; $display("FAIL click_pulse: got %b want 010", clicked); end
    step();
    total++; if (clicked !== 3'b000) begin bad++; $display("FAIL click_one_cycle: got %b want 000", clicked); end
  endtask

  task automatic test_drag();
    int pulses = 0;
    move(500, 440);
    mouse_left = 1'b1; step(); step();
    move(10, 10);
    mouse_left = 1'b0;
    repeat (4) begin step(); if (clicked !== 3'b000) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL drag_off: got %0d pulses want 0", pulses); end
    move(10, 10);
    mouse_left = 1'b1; step(); step();
    move(500, 680);
    mouse_left = 1'b0;
    pulses = 0;
    repeat (4) begin step(); if (clicked !== 3'b000) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL drag_on: got %0d pulses want 0", pulses); end
    mouse_left = 1'b1; step(); step();
    mouse_left = 1'b0; step();
    total++; if (clicked !== 3'b100) begin bad++; $display("FAIL click_after_drag: got %b want 100", clicked); end
  endtask

  task automatic test_enable_drop();
    int pulses = 0;
    bit v; vout_t e, g;
    enable = 3'b111;
    move(500, 440);
    mouse_left = 1'b1; step(); step();
    enable = 3'b110; step(); step();
    mouse_left = 1'b0;
    repeat (4) begin step(); if (clicked !== 3'b000) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL enable_drop_click: got %0d pulses want 0", pulses); end
    total++; if (hover !== 3'b000) begin bad++; $display("FAIL enable_drop_hover: got %b want 000", hover); end
    vq.delete();
    video_cycle(440, 410, 0, 0, 12'h5A5, -1, v, e, g);
    video_cycle(470, 435, 0, 0, 12'h3C3, -1, v, e, g);
    total++; if (g.rgb !== 12'h5A5) begin bad++; $display("FAIL disabled_fill: got %h want 5A5", g.rgb); end
    video_cycle(0, 0, 0, 0, 12'h000, -1, v, e, g);
    total++; if (g.rgb !== 12'h3C3) begin bad++; $display("FAIL disabled_text: got %h want 3C3", g.rgb); end
    // drop and restore while held: still blocked until release
    enable = 3'b111; step();
    mouse_left = 1'b1; step(); step();
    enable = 3'b110; step();
    enable = 3'b111; step(); step();
    mouse_left = 1'b0;
    pulses = 0;
    repeat (4) begin step(); if (clicked !== 3'b000) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL enable_glitch_click: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_text();
    bit v; vout_t e, g;
    enable = 3'b111;
    move(10, 10);
    vid.hcount_in = 12'd489; vid.vcount_in = 12'd557;
    #1;
    total++; if ({text_addr, char_line} !== {6'h13, 4'd5}) begin bad++; $display("FAIL text_addr: got %h/%h want 13/5", text_addr, char_line); end
    font_force = 1'b1; font_val = 8'h80;
    vq.delete();
    video_cycle(464, 432, 0, 0, 12'h111, -1, v, e, g);
    video_cycle(465, 432, 0, 0, 12'h111, -1, v, e, g);
    total++; if (g.rgb !== 12'hFFF) begin bad++; $display("FAIL text_pixel: got %h want FFF", g.rgb); end
    video_cycle(464, 432, 0, 1, 12'h111, -1, v, e, g);
    total++; if (g.rgb !== 12'h444) begin bad++; $display("FAIL text_bg_pixel: got %h want 444", g.rgb); end
    video_cycle(0, 0, 0, 0, 12'h000, -1, v, e, g);
    total++; if (g.rgb !== 12'h000) begin bad++; $display("FAIL vblank_black: got %h want 000", g.rgb); end
    font_force = 1'b0;
  endtask

  task automatic test_reset_midpress();
    int pulses = 0;
    move(500, 560);
    mouse_left = 1'b1; step(); step();
    rst = 1'b1; step();
    rst = 1'b0; step(); step();
    mouse_left = 1'b0;
    repeat (4) begin step(); if (clicked !== 3'b000) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL reset_midpress: got %0d pulses want 0", pulses); end
    mouse_left = 1'b1; step(); step();
    mouse_left = 1'b0; step();
    total++; if (clicked !== 3'b010) begin bad++; $display("FAIL repress_click: got %b want 010", clicked); end
  endtask

  task automatic test_back_to_back();
    int px[5] = '{500, 500, 500, 10, 559};
    int py[5] = '{440, 560, 680, 10, 599};
    enable = 3'b111;
    for (int i = 0; i < 20; i++) begin
      int a = int'($urandom_range(0, 4));
      int r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : a;
      int pb = btn_at(px[a], py[a], enable);
      int rb = btn_at(px[r], py[r], enable);
      logic [2:0] exp_c = (pb >= 0 && pb == rb) ? 3'(1 << pb) : 3'b000;
      move(px[a], py[a]);
      mouse_left = 1'b1; step(); step();
      move(px[r], py[r]);
      mouse_left = 1'b0; step();
      total++; if (clicked !== exp_c) begin bad++; $display("FAIL b2b_click[%0d]: got %b want %b", i, clicked, exp_c); end
      step();
      total++; if (clicked !== 3'b000) begin bad++; $display("FAIL b2b_clear[%0d]: got %b want 000", i, clicked); end
    end
  endtask

  initial begin
    test_reset();
    test_hover();
    test_video();
    test_click();
    test_drag();
    test_enable_drop();
    test_text();
    test_reset_midpress();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
